// File: rtl/fc_argmax.sv
// rtl/fc_argmax.sv - streaming argmax over M signed samples; FC_ARGMAX_TIE_LAST_EN selects highest index on ties
module fc_argmax #(
    parameter int M = 15,
    parameter int T = 19
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 input_valid,
    output logic                 input_ready,
    input  logic signed [T-1:0]  input_data,
    output logic                 output_valid,
    input  logic                 output_ready,
    output logic [$clog2(M)-1:0] output_index,
    output logic signed [T-1:0]  output_max
);
    localparam int IW = $clog2(M);

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [IW-1:0]        count;
    logic signed [T-1:0]  run_max;
    logic [IW-1:0]        run_idx;
    logic                 in_hs;
    logic                 out_hs;
    logic                 last;
    logic                 take;
    logic signed [T-1:0]  new_max;
    logic [IW-1:0]        new_idx;

    assign input_ready  = (state == LOAD) && !reset;
    assign output_valid = (state == HOLD);
    assign in_hs        = input_valid && input_ready;
    assign out_hs       = output_valid && output_ready;
    assign last         = (count == IW'(M - 1));

    // Element 0 always seeds the running max, whatever the tie mode.
`ifdef FC_ARGMAX_TIE_LAST_EN
    assign take = (count == '0) || (input_data >= run_max);
`else
    assign take = (count == '0) || (input_data > run_max);
`endif

    assign new_max = take ? input_data : run_max;
    assign new_idx = take ? count : run_idx;

    always_comb begin
        state_next = state;
        case (state)
            LOAD: if (in_hs && last) state_next = HOLD;
            HOLD: if (out_hs)        state_next = LOAD;
            default:                 state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LOAD;
            count        <= '0;
            run_max      <= '0;
            run_idx      <= '0;
            output_index <= '0;
            output_max   <= '0;
        end else begin
            state <= state_next;
            if (in_hs) begin
                count   <= last ? '0 : count + IW'(1);
                run_max <= new_max;
                run_idx <= new_idx;
                // Result registers change only on HOLD entry.
                if (last) begin
                    output_max   <= new_max;
                    output_index <= new_idx;
                end
            end
        end
    end
endmodule

// File: doc/fc_argmax.md
FC_ARGMAX -- requirements
Module: fc_argmax

Interface
REQ-001 SHALL provide parameter M, default 15, meaning the number of values per vector; M >= 2.
REQ-002 SHALL provide parameter T, default 19, meaning the signed sample width in bits.
REQ-003 SHALL define localparam IW = $clog2(M), the index width.
REQ-004 SHALL provide port: clk, input, 1, clock; all logic on rising edge.
REQ-005 SHALL provide port: reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL provide port: input_valid, input, 1, upstream sample valid.
REQ-007 SHALL provide port: input_ready, output, 1, block accepts a sample this cycle.
REQ-008 SHALL provide port: input_data, input, T, signed two's-complement sample from the upstream fc stage.
REQ-009 SHALL provide port: output_valid, output, 1, result available.
REQ-010 SHALL provide port: output_ready, input, 1, downstream accepts the result.
REQ-011 SHALL provide port: output_index, output, IW, position (0..M-1) of the maximum value in the vector.
REQ-012 SHALL provide port: output_max, output, T, signed maximum value.

Function
REQ-013 SHALL implement a two-state FSM: LOAD (accepting samples) and HOLD (presenting the result).
REQ-014 SHALL drive input_ready = 1 in LOAD and 0 in HOLD, as a registered-state decode with no combinational path from output_ready.
REQ-015 SHALL define an input handshake as input_valid && input_ready; cycles without a handshake leave all state unchanged.
REQ-016 SHALL keep a sample counter of 0..M-1 that increments on each handshake and wraps to 0 on the M-th handshake.
REQ-017 SHALL, on the handshake at count 0, load the running max with input_data and the running index with 0 unconditionally.
REQ-018 SHALL, on a handshake at count k > 0, replace the max/index with input_data/k when input_data is signed-greater than the running max (ties resolved by REQ-030).
REQ-019 SHALL use a full-width signed T-bit comparison with no saturation or truncation.
REQ-020 SHALL, on the M-th handshake, move the FSM to HOLD and assert output_valid the next cycle, giving a latency of 1 cycle from the last input handshake.
REQ-021 SHALL hold output_valid, output_index and output_max stable in HOLD until output_valid && output_ready.
REQ-022 SHALL, on an output handshake, return to LOAD and deassert output_valid the next cycle, with input_ready = 1 in that cycle.
REQ-023 SHALL have a minimum period of M+1 cycles per vector with output_ready tied high.
REQ-024 SHALL not change output_index or output_max while in LOAD; they retain the previous result until the next HOLD entry.

Reset
REQ-025 SHALL, while reset is high at a clock edge, set the state to LOAD, counter 0, output_valid 0, output_index 0, output_max 0 and running max/index 0.
REQ-026 SHALL force input_ready to 0 during any cycle in which reset is high.
REQ-027 SHALL discard a partially received vector when reset occurs mid-vector; the first handshake after reset is element 0.
REQ-028 SHALL give reset priority over any simultaneous input or output handshake.

Configuration
REQ-029 SHALL use the macro FC_ARGMAX_TIE_LAST_EN to select tie-breaking.
REQ-030 SHALL, without the macro, keep the lowest index on equal values (strict greater-than); with the macro defined, take the highest index on equal values (greater-or-equal), with element 0 still loaded unconditionally.

Verification
REQ-031 SHALL cover: inputs 0,1,...,14 back-to-back, output_ready=1 -> output_index=14, output_max=14, output_valid exactly 1 cycle after the 15th handshake.
REQ-032 SHALL cover: all 15 inputs = -5 -> output_index=0, output_max=-5 without the macro; output_index=14 with FC_ARGMAX_TIE_LAST_EN.
REQ-033 SHALL cover: all inputs -262144 except element 7 = 262143 -> output_index=7, output_max=262143.
REQ-034 SHALL cover: output_ready held 0 for 10 cycles after output_valid -> outputs stable, input_ready=0; output_ready=1 -> LOAD next cycle and the next vector is computed correctly.
REQ-035 SHALL cover: reset pulsed after 6 handshakes, then a vector with 9 at element 3 and 0 elsewhere -> output_index=3, output_max=9.
REQ-036 SHALL cover: input_valid toggled every other cycle over vector {3,-1,8,8,2,...,0} -> output_index=2, output_max=8, identical to the gap-free run.
